// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the grant sequencer slice.
//   DEFAULT_N        : default number of requesters on the daisy chain
//   DEFAULT_HOLD_MAX : default maximum grant tenure in cycles
//   arb_state_e      : grant sequencer FSM state encoding
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

package arb_pkg;

    localparam int DEFAULT_N        = 4;
    localparam int DEFAULT_HOLD_MAX = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OWNED   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/tenure_counter.sv
// ---------------------------------------------------------------------------
// tenure_counter
// Counts the cycles a grant has been held. It is cleared on the grant edge,
// advances by one each enabled cycle and sticks at HOLD_MAX-1, so it can
// never wrap back to zero and hide an overlong tenure.
// Ports:
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset, count forced to 0
//   clear_i    : synchronous clear, wins over enable
//   enable_i   : advance the count by one this cycle
//   terminal_o : high while the count sits at HOLD_MAX-1
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tenure_counter
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = DEFAULT_HOLD_MAX,
    parameter int W        = $clog2(HOLD_MAX + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic terminal_o
);

    localparam logic [W-1:0] LAST = W'(HOLD_MAX - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Saturating increment: once LAST is reached further enables are ignored.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != LAST)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign terminal_o = (count_q == LAST);

endmodule

// File: rtl/grant_sequencer.sv
// ---------------------------------------------------------------------------
// grant_sequencer
// Sits in front of an external priority daisy chain. While idle it enables
// the chain, checks the returned grant vector for consistency and latches a
// valid one-hot grant. The grant is then held, with the chain frozen, until
// the owner releases it (done or request drop) or its tenure runs out. One
// RELEASE cycle separates consecutive tenures.
// Ports:
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   req        : raw request lines, bit 0 highest priority
//   gnt_in     : combinational grant vector from the chain
//   chain_cout : chain carry out, 1 when nothing was granted
//   done       : per-requester release strobe
//   chain_en   : carry in to the first chain cell, high only in IDLE
//   gnt_out    : registered one-hot grant
//   owner      : index of the grant holder, 0 when not busy
//   busy       : high while a grant is held
//   timeout    : one-cycle pulse when a tenure is force-ended
//   chain_err  : one-cycle pulse on an inconsistent chain response
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module grant_sequencer
    import arb_pkg::*;
#(
    parameter int N        = DEFAULT_N,
    parameter int HOLD_MAX = DEFAULT_HOLD_MAX
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         gnt_in,
    input  logic                 chain_cout,
    input  logic [N-1:0]         done,
    output logic                 chain_en,
    output logic [N-1:0]         gnt_out,
    output logic [$clog2(N)-1:0] owner,
    output logic                 busy,
    output logic                 timeout,
    output logic                 chain_err
);

    localparam int OW = $clog2(N);

    arb_state_e    state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [OW-1:0] owner_q, owner_d;
    logic          busy_q, busy_d;
    logic          timeout_q, timeout_d;
    logic          chainErr_q, chainErr_d;

    logic [N-1:0]  gntMinusOne;
    logic          isOneHot;
    logic          grantOk;
    logic          chainBad;
    logic          ownerRelease;
    logic          tenureTerminal;

    function automatic logic [OW-1:0] encodeIndex(input logic [N-1:0] vec);
        encodeIndex = '0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                encodeIndex = OW'(i);
            end
        end
    endfunction

    // A vector is one-hot when it is non-zero and clearing its lowest set
    // bit leaves nothing behind.
    assign gntMinusOne = gnt_in - {{(N-1){1'b0}}, 1'b1};
    assign isOneHot    = (gnt_in != '0) && ((gnt_in & gntMinusOne) == '0);

    // A grant is only trusted when the chain agrees it granted someone and
    // that someone is actually requesting.
    assign grantOk  = isOneHot && !chain_cout && ((req & gnt_in) != '0);
    assign chainBad = ((gnt_in != '0) && !isOneHot) ||
                      ((gnt_in == '0) && !chain_cout && (req != '0));

    // gnt_q is one-hot in OWNED, so masking with it selects the owner's bit
    // and non-owner done/req activity is ignored.
    assign ownerRelease = ((done & gnt_q) != '0) || ((req & gnt_q) == '0);

    tenure_counter #(
        .HOLD_MAX (HOLD_MAX)
    ) u_tenure (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    ((state_q == ST_IDLE) && grantOk),
        .enable_i   (state_q == ST_OWNED),
        .terminal_o (tenureTerminal)
    );

    // Next-state decode. An owner release is checked before the terminal
    // count so a release landing on the last cycle never reports a timeout.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        owner_d    = owner_q;
        busy_d     = busy_q;
        timeout_d  = 1'b0;
        chainErr_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                gnt_d   = '0;
                owner_d = '0;
                busy_d  = 1'b0;
                if (grantOk) begin
                    gnt_d   = gnt_in;
                    owner_d = encodeIndex(gnt_in);
                    busy_d  = 1'b1;
                    state_d = ST_OWNED;
                end else if (chainBad) begin
                    chainErr_d = 1'b1;
                end
            end
            ST_OWNED: begin
                if (ownerRelease || tenureTerminal) begin
                    timeout_d = !ownerRelease;
                    gnt_d     = '0;
                    owner_d   = '0;
                    busy_d    = 1'b0;
                    state_d   = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                gnt_d   = '0;
                owner_d = '0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                gnt_d   = '0;
                owner_d = '0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            owner_q    <= '0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
            chainErr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            owner_q    <= owner_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
            chainErr_q <= chainErr_d;
        end
    end

    // The chain is only enabled out of reset so it cannot produce a grant
    // that the sequencer is not in a position to accept.
    assign chain_en  = rst_n && (state_q == ST_IDLE);
    assign gnt_out   = gnt_q;
    assign owner     = owner_q;
    assign busy      = busy_q;
    assign timeout   = timeout_q;
    assign chain_err = chainErr_q;

endmodule

// File: tb/tb_grant_sequencer.sv
// ---------------------------------------------------------------------------
// tb_grant_sequencer
// Self-checking bench for grant_sequencer with N=4, HOLD_MAX=16. Single-cycle
// IDLE behaviour comes from a vector table; tenure release, timeout, the
// release/timeout collision and mid-tenure reset are hand-written sequences.
// Expected outputs are queued when inputs are driven and popped one edge later.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_grant_sequencer;

    localparam int N  = 4;
    localparam int HM = 16;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] owner;
        logic       busy;
        logic       timeout;
        logic       err;
        logic       chainEn;
    } exp_t;

    typedef struct packed {
        logic [3:0] req;
        logic [3:0] gntIn;
        logic       cout;
        logic [3:0] done;
        exp_t       want;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] gntIn = '0;
    logic       chainCout = 1'b1;
    logic [3:0] done = '0;
    logic       chainEn;
    logic [3:0] gntOut;
    logic [1:0] owner;
    logic       busy;
    logic       timeout;
    logic       chainErr;

    exp_t sbQ[$];
    int   testsRun  = 0;
    int   failCount = 0;

    grant_sequencer #(
        .N        (N),
        .HOLD_MAX (HM)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .gnt_in     (gntIn),
        .chain_cout (chainCout),
        .done       (done),
        .chain_en   (chainEn),
        .gnt_out    (gntOut),
        .owner      (owner),
        .busy       (busy),
        .timeout    (timeout),
        .chain_err  (chainErr)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 100000");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mkVec(
        input logic [3:0] r, input logic [3:0] g, input logic c, input logic [3:0] d,
        input logic [3:0] eg, input logic [1:0] eo, input logic eb, input logic et,
        input logic ee, input logic een);
        vec_t v;
        v.req          = r;
        v.gntIn        = g;
        v.cout         = c;
        v.done         = d;
        v.want.gnt     = eg;
        v.want.owner   = eo;
        v.want.busy    = eb;
        v.want.timeout = et;
        v.want.err     = ee;
        v.want.chainEn = een;
        return v;
    endfunction

    task automatic checkVal(input string name, input int tag,
                            input logic [31:0] act, input logic [31:0] req32);
        testsRun++;
        if (act !== req32) begin
            failCount++;
            $display("[TB] FAIL %s (step %0d): got %0h, expected %0h", name, tag, act, req32);
        end
    endtask

    // Pops the expectation queued for the edge that just happened.
    task automatic checkOutput(input int tag);
        exp_t w;
        if (sbQ.size() == 0) begin
            testsRun++;
            failCount++;
            $display("[TB] FAIL scoreboard (step %0d): got 0 entries, expected 1", tag);
        end else begin
            w = sbQ.pop_front();
            checkVal("gnt_out",   tag, 32'(gntOut),   32'(w.gnt));
            checkVal("owner",     tag, 32'(owner),    32'(w.owner));
            checkVal("busy",      tag, 32'(busy),     32'(w.busy));
            checkVal("timeout",   tag, 32'(timeout),  32'(w.timeout));
            checkVal("chain_err", tag, 32'(chainErr), 32'(w.err));
            checkVal("chain_en",  tag, 32'(chainEn),  32'(w.chainEn));
        end
    endtask

    // Drive one cycle of inputs at the falling edge, check 1 unit after the
    // following rising edge.
    task automatic applyStimulus(input vec_t v, input int tag);
        @(negedge clk);
        req       = v.req;
        gntIn     = v.gntIn;
        chainCout = v.cout;
        done      = v.done;
        sbQ.push_back(v.want);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    // Two quiet cycles: leaves OWNED via request drop, or just idles.
    task automatic drainToIdle(input logic wasBusy, input int tag);
        applyStimulus(mkVec(4'b0000, 4'b0000, 1'b1, 4'b0000,
                            4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, !wasBusy), tag);
        applyStimulus(mkVec(4'b0000, 4'b0000, 1'b1, 4'b0000,
                            4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1), tag + 50);
    endtask

    vec_t table_v[10];

    initial begin
        // req, gnt_in, cout, done -> gnt_out, owner, busy, timeout, chain_err, chain_en
        table_v[0] = mkVec(4'b0100, 4'b0100, 1'b0, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        table_v[1] = mkVec(4'b0001, 4'b0001, 1'b0, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        table_v[2] = mkVec(4'b1000, 4'b1000, 1'b0, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        table_v[3] = mkVec(4'b0110, 4'b0110, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        table_v[4] = mkVec(4'b0010, 4'b0000, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        table_v[5] = mkVec(4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        table_v[6] = mkVec(4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        table_v[7] = mkVec(4'b1111, 4'b0011, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        table_v[8] = mkVec(4'b1010, 4'b0010, 1'b0, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        table_v[9] = mkVec(4'b0100, 4'b0100, 1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset state, including chain_en held low during reset.
        repeat (2) @(posedge clk);
        #1;
        checkVal("rst gnt_out",   0, 32'(gntOut),   32'h0);
        checkVal("rst owner",     0, 32'(owner),    32'h0);
        checkVal("rst busy",      0, 32'(busy),     32'h0);
        checkVal("rst timeout",   0, 32'(timeout),  32'h0);
        checkVal("rst chain_err", 0, 32'(chainErr), 32'h0);
        checkVal("rst chain_en",  0, 32'(chainEn),  32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkVal("post-rst chain_en", 0, 32'(chainEn), 32'h1);

        // Table: one IDLE decision per entry, then back to idle.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(table_v[i], i + 1);
            drainToIdle(table_v[i].want.busy, i + 20);
        end

        // Owner 2 holds for 5 cycles, then releases with done.
        applyStimulus(mkVec(4'b0100, 4'b0100, 1'b0, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0), 100);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(mkVec(4'b0100, 4'b0000, 1'b1, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0), 100 + k);
        end
        applyStimulus(mkVec(4'b0100, 4'b0000, 1'b1, 4'b0100, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), 105);
        applyStimulus(mkVec(4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1), 106);

        // Owner 1 never releases: timeout exactly 16 edges after the grant.
        applyStimulus(mkVec(4'b0010, 4'b0010, 1'b0, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0), 200);
        for (int k = 1; k < HM; k++) begin
            applyStimulus(mkVec(4'b0010, 4'b0000, 1'b1, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0), 200 + k);
        end
        applyStimulus(mkVec(4'b0010, 4'b0000, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0), 200 + HM);
        applyStimulus(mkVec(4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1), 201 + HM);

        // Owner 3 with non-owner done/req noise, then done on the terminal cycle.
        applyStimulus(mkVec(4'b1111, 4'b1000, 1'b0, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0), 300);
        for (int k = 1; k < HM; k++) begin
            applyStimulus(mkVec((k % 2 == 1) ? 4'b1000 : 4'b1111, 4'b0000, 1'b1, 4'b0111,
                                4'b1000, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0), 300 + k);
        end
        applyStimulus(mkVec(4'b1000, 4'b0000, 1'b1, 4'b1000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), 300 + HM);
        applyStimulus(mkVec(4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1), 301 + HM);

        // Reset between edges mid-tenure, then a grant on the first edge after.
        applyStimulus(mkVec(4'b0100, 4'b0100, 1'b0, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0), 400);
        applyStimulus(mkVec(4'b0100, 4'b0000, 1'b1, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0), 401);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkVal("async gnt_out",  402, 32'(gntOut),  32'h0);
        checkVal("async busy",     402, 32'(busy),    32'h0);
        checkVal("async owner",    402, 32'(owner),   32'h0);
        checkVal("async chain_en", 402, 32'(chainEn), 32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        applyStimulus(mkVec(4'b0001, 4'b0001, 1'b0, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0), 403);
        drainToIdle(1'b1, 404);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/grant_sequencer.md
GRANT_SEQUENCER -- requirements
Module: grant_sequencer

Interface
REQ-001 SHALL have parameter N, default 4: number of requesters (chain length); legal range 2..32.
REQ-002 SHALL have parameter HOLD_MAX, default 16: maximum grant tenure in cycles; legal range 2..255.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req  input  N  raw request lines, also driven into the daisy chain; bit 0 is highest priority.
REQ-006 SHALL have port gnt_in  input  N  combinational grant vector returned by the daisy chain.
REQ-007 SHALL have port chain_cout  input  1  carry out of the last chain cell; 1 means no request was granted.
REQ-008 SHALL have port done  input  N  per-requester release strobe.
REQ-009 SHALL have port chain_en  output  1  carry in to the first chain cell.
REQ-010 SHALL have port gnt_out  output  N  registered, held one-hot grant.
REQ-011 SHALL have port owner  output  $clog2(N)  index of the current grant holder; 0 when not busy.
REQ-012 SHALL have port busy  output  1  high while a grant is held.
REQ-013 SHALL have port timeout  output  1  one-cycle pulse when a tenure is force-ended.
REQ-014 SHALL have port chain_err  output  1  one-cycle pulse on an inconsistent chain response.

Function
REQ-015 SHALL implement a 3-state FSM: IDLE, OWNED, RELEASE.
REQ-016 SHALL drive chain_en=1 in IDLE only and 0 in OWNED and RELEASE, freezing the chain during a tenure.
REQ-017 In IDLE, when gnt_in is one-hot, chain_cout=0 and req has that bit set, SHALL latch gnt_in into gnt_out, set owner to its index, clear the tenure counter and enter OWNED on the same edge (1-cycle latency from req to gnt_out).
REQ-018 In IDLE, when gnt_in is non-zero and not one-hot, or gnt_in=0 while chain_cout=0 and req!=0, SHALL pulse chain_err, hold gnt_out=0 and remain in IDLE.
REQ-019 In IDLE with req=0, SHALL stay in IDLE with no error pulse, whatever chain_cout is.
REQ-020 In OWNED, SHALL hold gnt_out and owner constant and increment the tenure counter by 1 each cycle; counter width is $clog2(HOLD_MAX+1); it saturates and never wraps.
REQ-021 In OWNED, done[owner]=1 or req[owner]=0 SHALL clear gnt_out on the next edge and enter RELEASE.
REQ-022 In OWNED, when the counter reaches HOLD_MAX-1 without a release, SHALL pulse timeout on the next cycle, clear gnt_out and enter RELEASE.
REQ-023 When done and timeout coincide in the same cycle, SHALL treat it as a normal release with no timeout pulse.
REQ-024 SHALL ignore done and req bits of non-owners in OWNED.
REQ-025 SHALL spend exactly one cycle in RELEASE with gnt_out=0 and busy=0, then enter IDLE; minimum gap between tenures is 2 cycles.
REQ-026 SHALL keep busy=1 exactly when the state is OWNED.
REQ-027 SHALL keep gnt_out zero or one-hot at all times.

Reset
REQ-028 While rst_n=0, SHALL force asynchronously: state=IDLE, gnt_out=0, owner=0, busy=0, timeout=0, chain_err=0, counter=0; chain_en SHALL be 0 during reset.
REQ-029 Reset asserted mid-tenure SHALL drop gnt_out within the same cycle, without waiting for a clock edge.
REQ-030 After rst_n deasserts, SHALL be able to grant on the first rising edge.

Structure
REQ-031 Shared package arb_pkg SHALL hold the FSM state enum and the default N and HOLD_MAX constants.
REQ-032 The tenure counter SHALL be a sub-module, tenure_counter, with clear, enable, saturate-at-HOLD_MAX-1 behaviour and a terminal flag.
REQ-033 The one-hot check and the index encode SHALL be combinational logic inside grant_sequencer.

Verification
REQ-034 N=4: req=0100, gnt_in=0100, chain_cout=0 -> next edge gnt_out=0100, owner=2, busy=1, chain_en=0.
REQ-035 Holder 2 asserts done[2] after 5 cycles -> gnt_out=0000 next edge, 1 cycle RELEASE, chain_en=1 the following cycle, no timeout.
REQ-036 HOLD_MAX=16, holder never releases -> timeout pulse exactly once, 16 cycles after the grant edge, then gnt_out=0.
REQ-037 gnt_in=0110 in IDLE -> chain_err pulses 1 cycle, gnt_out stays 0; same with req=0010, gnt_in=0000, chain_cout=0.
REQ-038 done[owner] and terminal count in the same cycle -> RELEASE, timeout stays 0; done[non-owner] during OWNED -> no effect.
REQ-039 rst_n pulled low mid-tenure between edges -> gnt_out=0 and busy=0 immediately; after release, req=0001 grants on the first edge.
